mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Bus initiator for the LC-3 core's data memory. Accepts one load/store request at a time from the core's execute stage. Sequences the `read`/`write` strobes, address and write data into the single-port synchronous RAM, and returns read data with a one-cycle `done` pulse. Resolves indirect accesses (LDI/STI) by fetching a pointer word first, then performing the real access through it.

## Interface
Parameters:
- `WORD_SIZE`, 16, data width; must match the RAM.
- `ADDRESS_SIZE`, 16, address width; must match the RAM. `WORD_SIZE >= ADDRESS_SIZE`.

Ports:
- Clock and reset (already decided): one clock, `clock`. Reset is `reset`, synchronous and active-high.
- `clock` in 1 — system clock; all state updates on its rising edge.
- `reset` in 1 — synchronous, active-high.
- `req` in 1 — request strobe; sampled only when `ready=1`.
- `op_write` in 1 — 1 = store, 0 = load.
- `op_indirect` in 1 — 1 = address names a pointer word (LDI/STI).
- `req_address` in ADDRESS_SIZE — effective address from the core.
- `req_wdata` in WORD_SIZE — store data.
- `ready` out 1 — idle; can accept `req` this cycle.
- `done` out 1 — one-cycle pulse at completion.
- `rdata` out WORD_SIZE — load result; held until the next load completes.
- `mem_read` out 1 — to RAM `read`.
- `mem_write` out 1 — to RAM `write`.
- `mem_address` out ADDRESS_SIZE — to RAM `address`.
- `mem_wdata` out WORD_SIZE — to RAM `in_data`.
- `mem_rdata` in WORD_SIZE — from RAM `out_data`; valid the cycle after `mem_read` was high.

## Operation
- States: IDLE, PTR, PTR_WAIT, RD, RD_WAIT, WR, DONE.
- **IDLE:** `ready=1`. On `req`, latch `addr_q<=req_address`, `wdata_q<=req_wdata`, `wr_q<=op_write`. Next state:
  - PTR if `op_indirect`.
  - else WR if `op_write`.
  - else RD.
- **PTR:** `mem_read=1`, `mem_address=addr_q`. Next state PTR_WAIT.
- **PTR_WAIT:** `addr_q <= mem_rdata[ADDRESS_SIZE-1:0]`. Next state WR if `wr_q`, else RD.
- **RD:** `mem_read=1`. Next state RD_WAIT.
- **RD_WAIT:** `rdata <= mem_rdata`. Next state DONE.
- **WR:** `mem_write=1`, `mem_wdata=wdata_q`. Next state DONE.
- **DONE:** `done=1`, `ready=0`. Next state IDLE.
- Output rules:
  - `mem_address=addr_q` in every state.
  - `mem_wdata=wdata_q` in every state.
  - `mem_read` and `mem_write` are never high together.
- A `req` while `ready=0` is ignored; no queueing.
- `op_*`, `req_address` and `req_wdata` are don't-care except in the accept cycle.
- The pointer word is truncated to ADDRESS_SIZE; upper bits are ignored.
- Address arithmetic is not performed here; the core supplies final addresses.

## Timing
- Let cycle 0 be the cycle in which `req` is accepted. `done` is high in:
  - direct store: cycle 2
  - direct load: cycle 3
  - indirect store: cycle 4
  - indirect load: cycle 5
- `rdata` is valid from the `done` cycle onward.
- `ready` returns the cycle after `done`. Minimum request spacing is therefore latency+1.
- Reset values:
  - state IDLE, `ready=1`, `done=0`
  - `mem_read=0`, `mem_write=0`
  - `addr_q=0`, so `mem_address=0`
  - `wdata_q=0`, so `mem_wdata=0`
  - `rdata=0`
- Reset mid-operation: the block returns to IDLE on the reset edge and strobes drop that edge. A write strobe already sampled by the RAM completes; no `done` is issued.
- `reset` and `req` high together: reset wins; the request is dropped.

## Structure
- Package `lc3_mem_pkg` holds:
  - the state enum (3-bit encoding)
  - default `WORD_SIZE`/`ADDRESS_SIZE` constants, shared with the RAM
- Single flat module: one state register plus `addr_q`/`wdata_q`/`wr_q`/`rdata`. No sub-module.
- Bench instantiates the existing RAM as the responder.

## Test plan
- **Direct load:** RAM[0x0010]=0x1261; req, load, addr 0x0010.
  - `mem_read` high in cycle 1 only.
  - `done` in cycle 3 with `rdata=0x1261`.
- **Direct store:** req, store, addr 0x0020, wdata 0xBEEF.
  - `mem_write` high in cycle 1.
  - `done` in cycle 2.
  - A subsequent load of 0x0020 returns 0xBEEF.
- **Indirect load:** RAM[0x0005]=0x0000, RAM[0x0000]=0x1021; LDI-style req at 0x0005.
  - `mem_address` is 0x0005 in cycle 1, then 0x0000 in cycle 3.
  - `done` in cycle 5 with `rdata=0x1021`.
- **Indirect store:** RAM[0x0006]=0x0003; STI-style req at 0x0006, wdata 0x1021.
  - `mem_write` in cycle 3 at address 0x0003.
  - `done` in cycle 4.
  - RAM[0x0003]=0x1021.
- **Busy / reset:**
  - `req` held high during an indirect load: a second request is accepted only the cycle after `done`.
  - `reset` asserted in PTR_WAIT: next cycle `ready=1`, strobes 0, `rdata` 0, no `done`.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - shared types and sizes for the LC-3 data memory path
//
// Package lc3_mem_pkg. It holds the data memory word and address widths, which
// the RAM also uses, and the 3-bit state encoding of mem_access_unit.

package lc3_mem_pkg;

  localparam int LC3_WORD_SIZE    = 16;
  localparam int LC3_ADDRESS_SIZE = 16;

  // Code 3'd7 is unused. The FSM falls back to IDLE if it ever sees it.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PTR      = 3'd1,
    ST_PTR_WAIT = 3'd2,
    ST_RD       = 3'd3,
    ST_RD_WAIT  = 3'd4,
    ST_WR       = 3'd5,
    ST_DONE     = 3'd6
  } mau_state_t;

endpackage

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - core request and RAM bus interfaces of mem_access_unit
//
// mem_req_if: execute stage <-> mem_access_unit.
//   master (core): drives req, op_write, op_indirect, req_address, req_wdata.
//                  Receives ready, done, rdata.
//   slave  (unit): the mirror image of master.
// mem_bus_if: mem_access_unit <-> single-port synchronous RAM.
//   master (unit): drives mem_read, mem_write, mem_address, mem_wdata.
//                  Receives mem_rdata.
//   slave  (RAM):  the mirror image of master. mem_rdata is valid the cycle
//                  after mem_read.

interface mem_req_if
  import lc3_mem_pkg::*;
#(
  parameter int WORD_SIZE    = LC3_WORD_SIZE,
  parameter int ADDRESS_SIZE = LC3_ADDRESS_SIZE
);
  logic                    req;
  logic                    op_write;
  logic                    op_indirect;
  logic [ADDRESS_SIZE-1:0] req_address;
  logic [WORD_SIZE-1:0]    req_wdata;
  logic                    ready;
  logic                    done;
  logic [WORD_SIZE-1:0]    rdata;

  modport master (
    output req, op_write, op_indirect, req_address, req_wdata,
    input  ready, done, rdata
  );

  modport slave (
    input  req, op_write, op_indirect, req_address, req_wdata,
    output ready, done, rdata
  );
endinterface

interface mem_bus_if
  import lc3_mem_pkg::*;
#(
  parameter int WORD_SIZE    = LC3_WORD_SIZE,
  parameter int ADDRESS_SIZE = LC3_ADDRESS_SIZE
);
  logic                    mem_read;
  logic                    mem_write;
  logic [ADDRESS_SIZE-1:0] mem_address;
  logic [WORD_SIZE-1:0]    mem_wdata;
  logic [WORD_SIZE-1:0]    mem_rdata;

  modport master (
    output mem_read, mem_write, mem_address, mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_read, mem_write, mem_address, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - LC-3 data memory bus initiator with LDI/STI pointer resolution
//
// Accepts one load or store at a time from the execute stage and drives the
// single-port synchronous RAM. An indirect access first reads a pointer word.
// The unit then performs the real access at the address held in that word.
//
// Ports:
//   clock  system clock; all state changes on the rising edge
//   reset  synchronous, active-high
//   core   mem_req_if.slave: req/op_write/op_indirect/req_address/req_wdata in;
//          ready/done/rdata out
//   bus    mem_bus_if.master: mem_read/mem_write/mem_address/mem_wdata out;
//          mem_rdata in
//
// done is high in these cycles, counting the accept cycle as 0:
//   direct store 2, direct load 3, indirect store 4, indirect load 5.

module mem_access_unit
  import lc3_mem_pkg::*;
#(
  parameter int WORD_SIZE    = LC3_WORD_SIZE,
  parameter int ADDRESS_SIZE = LC3_ADDRESS_SIZE
) (
  input  logic      clock,
  input  logic      reset,
  mem_req_if.slave  core,
  mem_bus_if.master bus
);

  mau_state_t state;
  mau_state_t state_next;

  logic [ADDRESS_SIZE-1:0] addr_q;
  logic [WORD_SIZE-1:0]    wdata_q;
  logic [WORD_SIZE-1:0]    rdata_q;
  logic                    wr_q;

  logic ready_c;
  logic done_c;
  logic mem_read_c;
  logic mem_write_c;

  // The state register and the datapath registers.
  // addr_q serves twice. It first holds the pointer address. After PTR_WAIT it
  // holds the target address, so mem_address can follow addr_q in every state.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wr_q    <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        ST_IDLE: begin
          if (core.req) begin
            addr_q  <= core.req_address;
            wdata_q <= core.req_wdata;
            wr_q    <= core.op_write;
          end
        end
        ST_PTR_WAIT: begin
          // Only the low ADDRESS_SIZE bits of the pointer word form the address.
          addr_q <= bus.mem_rdata[ADDRESS_SIZE-1:0];
        end
        ST_RD_WAIT: begin
          rdata_q <= bus.mem_rdata;
        end
        default: ;
      endcase
    end
  end

  // Next-state and strobe decode. The strobes depend only on the state.
  // A reset therefore drops them on the same edge that returns the FSM to IDLE.
  always_comb begin
    state_next  = state;
    ready_c     = 1'b0;
    done_c      = 1'b0;
    mem_read_c  = 1'b0;
    mem_write_c = 1'b0;
    case (state)
      ST_IDLE: begin
        ready_c = 1'b1;
        if (core.req) begin
          if (core.op_indirect) begin
            state_next = ST_PTR;
          end else if (core.op_write) begin
            state_next = ST_WR;
          end else begin
            state_next = ST_RD;
          end
        end
      end
      ST_PTR: begin
        mem_read_c = 1'b1;
        state_next = ST_PTR_WAIT;
      end
      ST_PTR_WAIT: begin
        state_next = wr_q ? ST_WR : ST_RD;
      end
      ST_RD: begin
        mem_read_c = 1'b1;
        state_next = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        state_next = ST_DONE;
      end
      ST_WR: begin
        mem_write_c = 1'b1;
        state_next  = ST_DONE;
      end
      ST_DONE: begin
        done_c     = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign core.ready      = ready_c;
  assign core.done       = done_c;
  assign core.rdata      = rdata_q;
  assign bus.mem_read    = mem_read_c;
  assign bus.mem_write   = mem_write_c;
  assign bus.mem_address = addr_q;
  assign bus.mem_wdata   = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit

module tb_mem_access_unit;
  import lc3_mem_pkg::*;

  localparam int W = LC3_WORD_SIZE;
  localparam int A = LC3_ADDRESS_SIZE;
  localparam int NT = 12;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  mem_req_if #(.WORD_SIZE(W), .ADDRESS_SIZE(A)) core ();
  mem_bus_if #(.WORD_SIZE(W), .ADDRESS_SIZE(A)) bus ();

  mem_access_unit #(.WORD_SIZE(W), .ADDRESS_SIZE(A)) dut (
    .clock (clock),
    .reset (reset),
    .core  (core),
    .bus   (bus)
  );

  // Behavioural single-port synchronous RAM acting as the responder. It has
  // a bench-side preload port.
  logic [W-1:0] ram [0:(1<<A)-1];
  logic [W-1:0] ram_out = '0;
  logic         pl_we = 1'b0;
  logic [A-1:0] pl_addr = '0;
  logic [W-1:0] pl_data = '0;

  always @(posedge clock) begin
    if (pl_we) ram[pl_addr] <= pl_data;
    else if (bus.mem_write) ram[bus.mem_address] <= bus.mem_wdata;
    if (bus.mem_read) ram_out <= ram[bus.mem_address];
  end
  assign bus.mem_rdata = ram_out;

  int n_vec = 0;
  int n_bad = 0;
  int overlap = 0;

  logic         tr_ready [0:NT-1];
  logic         tr_done  [0:NT-1];
  logic         tr_read  [0:NT-1];
  logic         tr_write [0:NT-1];
  logic [A-1:0] tr_addr  [0:NT-1];
  logic [W-1:0] tr_wdata [0:NT-1];
  logic [W-1:0] tr_rdata [0:NT-1];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic sample(input int c);
    tr_ready[c] = core.ready;
    tr_done[c]  = core.done;
    tr_read[c]  = bus.mem_read;
    tr_write[c] = bus.mem_write;
    tr_addr[c]  = bus.mem_address;
    tr_wdata[c] = bus.mem_wdata;
    tr_rdata[c] = core.rdata;
    if (bus.mem_read && bus.mem_write) overlap++;
  endtask

  task automatic preload(input logic [A-1:0] a, input logic [W-1:0] d);
    @(posedge clock);
    #1;
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clock);
    #1;
    pl_we = 1'b0;
  endtask

  // Raise req with its operands and record cycle 0, the accept cycle.
  task automatic start_req(input logic w, input logic ind, input logic [A-1:0] a, input logic [W-1:0] d);
    @(posedge clock);
    #1;
    core.req = 1'b1; core.op_write = w; core.op_indirect = ind;
    core.req_address = a; core.req_wdata = d;
    @(negedge clock);
    sample(0);
  endtask

  // Record cycles 1..n. After the accept edge the operands change to the n*
  // values. req drops in cycle drop_at.
  task automatic trace(input int n, input int drop_at, input logic nw, input logic nind,
                       input logic [A-1:0] na, input logic [W-1:0] nd);
    for (int c = 1; c <= n; c++) begin
      @(posedge clock);
      #1;
      if (c == 1) begin
        core.op_write = nw; core.op_indirect = nind;
        core.req_address = na; core.req_wdata = nd;
      end
      if (c == drop_at) core.req = 1'b0;
      @(negedge clock);
      sample(c);
    end
  endtask

  task automatic run_op(input logic w, input logic ind, input logic [A-1:0] a, input logic [W-1:0] d);
    start_req(w, ind, a, d);
    trace(8, 1, 1'($urandom), 1'($urandom), A'($urandom), W'($urandom));
  endtask

  function automatic int first_done(input int n);
    for (int c = 0; c <= n; c++) if (tr_done[c]) return c;
    return -1;
  endfunction

  function automatic int count_done(input int n);
    int k = 0;
    for (int c = 0; c <= n; c++) if (tr_done[c]) k++;
    return k;
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    reset = 1'b1;
    core.req = 1'b0; core.op_write = 1'b0; core.op_indirect = 1'b0;
    core.req_address = '0; core.req_wdata = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_ready", core.ready, 1);
    chk("rst_done", core.done, 0);
    chk("rst_mem_read", bus.mem_read, 0);
    chk("rst_mem_write", bus.mem_write, 0);
    chk("rst_mem_address", bus.mem_address, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_rdata", core.rdata, 0);
    reset = 1'b0;

    preload(16'h0010, 16'h1261);
    preload(16'h0005, 16'h0000);
    preload(16'h0000, 16'h1021);
    preload(16'h0006, 16'h0003);
    preload(16'h0030, 16'h0A0A);

    // Direct load
    run_op(1'b0, 1'b0, 16'h0010, 16'h0000);
    chk("dl_ready_c0", tr_ready[0], 1);
    chk("dl_read_c1", tr_read[1], 1);
    chk("dl_addr_c1", tr_addr[1], 16'h0010);
    chk("dl_read_c2", tr_read[2], 0);
    chk("dl_read_c3", tr_read[3], 0);
    chk("dl_done_cycle", first_done(8), 3);
    chk("dl_done_count", count_done(8), 1);
    chk("dl_rdata", tr_rdata[3], 16'h1261);
    chk("dl_ready_c4", tr_ready[4], 1);

    // Direct store, then a load back from the same address
    run_op(1'b1, 1'b0, 16'h0020, 16'hBEEF);
    chk("ds_write_c1", tr_write[1], 1);
    chk("ds_addr_c1", tr_addr[1], 16'h0020);
    chk("ds_wdata_c1", tr_wdata[1], 16'hBEEF);
    chk("ds_write_c2", tr_write[2], 0);
    chk("ds_done_cycle", first_done(8), 2);
    chk("ds_rdata_held", tr_rdata[2], 16'h1261);
    run_op(1'b0, 1'b0, 16'h0020, 16'h0000);
    chk("ds_readback_done", first_done(8), 3);
    chk("ds_readback", tr_rdata[3], 16'hBEEF);

    // Indirect load
    run_op(1'b0, 1'b1, 16'h0005, 16'h0000);
    chk("il_read_c1", tr_read[1], 1);
    chk("il_addr_c1", tr_addr[1], 16'h0005);
    chk("il_read_c2", tr_read[2], 0);
    chk("il_read_c3", tr_read[3], 1);
    chk("il_addr_c3", tr_addr[3], 16'h0000);
    chk("il_done_cycle", first_done(8), 5);
    chk("il_rdata", tr_rdata[5], 16'h1021);

    // Indirect store
    run_op(1'b1, 1'b1, 16'h0006, 16'h1021);
    chk("is_write_c1", tr_write[1], 0);
    chk("is_write_c3", tr_write[3], 1);
    chk("is_addr_c3", tr_addr[3], 16'h0003);
    chk("is_done_cycle", first_done(8), 4);
    chk("is_ram3", ram[16'h0003], 16'h1021);
    chk("is_rdata_held", tr_rdata[4], 16'h1021);

    // Busy: req stays high through an indirect load. The second request, a
    // direct load of 0x0010, may be taken only in the cycle after done.
    start_req(1'b0, 1'b1, 16'h0005, 16'h0000);
    trace(10, 7, 1'b0, 1'b0, 16'h0010, 16'h0000);
    k = 0;
    for (int c = 1; c <= 5; c++) if (tr_ready[c]) k++;
    chk("busy_not_ready_c1_5", k, 0);
    chk("busy_done_c5", tr_done[5], 1);
    chk("busy_rdata_c5", tr_rdata[5], 16'h1021);
    chk("busy_ready_c6", tr_ready[6], 1);
    chk("busy_read_c6", tr_read[6], 0);
    chk("busy_read_c7", tr_read[7], 1);
    chk("busy_addr_c7", tr_addr[7], 16'h0010);
    chk("busy_done_c9", tr_done[9], 1);
    chk("busy_rdata_c9", tr_rdata[9], 16'h1261);
    chk("busy_done_count", count_done(10), 2);

    // Reset asserted in PTR_WAIT
    start_req(1'b0, 1'b1, 16'h0005, 16'h0000);
    trace(2, 1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("rpw_read_c1", tr_read[1], 1);
    chk("rpw_rdata_before", tr_rdata[2], 16'h1261);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    chk("rpw_ready", core.ready, 1);
    chk("rpw_mem_read", bus.mem_read, 0);
    chk("rpw_mem_write", bus.mem_write, 0);
    chk("rpw_rdata", core.rdata, 0);
    chk("rpw_done", core.done, 0);
    chk("rpw_mem_address", bus.mem_address, 0);
    trace(6, 99, 1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("rpw_no_done_after", count_done(6), 0);

    // reset and req high together: reset wins and the store is dropped
    @(negedge clock);
    reset = 1'b1;
    core.req = 1'b1; core.op_write = 1'b1; core.op_indirect = 1'b0;
    core.req_address = 16'h0030; core.req_wdata = 16'h5555;
    @(posedge clock);
    #1;
    reset = 1'b0;
    core.req = 1'b0;
    trace(4, 99, 1'b0, 1'b0, 16'h0000, 16'h0000);
    k = 0;
    for (int c = 1; c <= 4; c++) if (tr_write[c] || !tr_ready[c]) k++;
    chk("rr_no_activity", k, 0);
    chk("rr_ram30", ram[16'h0030], 16'h0A0A);

    chk("never_read_and_write", overlap, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
